// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, bit-period rounding and frame constants.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_t;

    // Clock cycles per bit, rounded to nearest; also intended for the receiver.
    function automatic int uart_divisor(input int clk_mhz, input int baud_rate);
        return (clk_mhz * 1_000_000 + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering bytes for the UART transmitter.
// Pointers carry one extra bit so a full FIFO can be told apart from an empty one.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
            $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-oriented UART transmitter: valid/ready into a FIFO, serialised as 8N1 frames,
// or 8E1 frames when UART_TX_PARITY_EN is defined.
import uart_pkg::*;

module uart_tx #(
    parameter int clk_mhz    = 50,
    parameter int baud_rate  = 115200,
    parameter int fifo_depth = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] data,
    input  logic                      valid,
    output logic                      ready,
    output logic                      tx,
    output logic                      busy
);

    localparam int DIVISOR = uart_divisor(clk_mhz, baud_rate);
    localparam int CW      = $clog2(DIVISOR);
    localparam int IW      = $clog2(UART_DATA_BITS);

    generate
        if (DIVISOR < 2) begin : g_div_chk
            $error("uart_tx: bit period divisor must be >= 2");
        end
    endgenerate

    uart_tx_state_t            state, state_n;
    logic [CW-1:0]             bit_cnt;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_DATA_BITS-1:0] fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic                      last;
    logic                      tx_n;
`ifdef UART_TX_PARITY_EN
    logic                      par_bit;
`endif

    assign ready = !fifo_full;
    assign push  = valid && ready;
    assign last  = (bit_cnt == CW'(DIVISOR - 1));
    // Popping on the final STOP cycle chains frames without an idle gap.
    assign pop   = !fifo_empty && (state == ST_IDLE || (state == ST_STOP && last));

    uart_tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        tx_n    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (pop) state_n = ST_START;
            end
            ST_START: begin
                tx_n = 1'b0;
                if (last) state_n = ST_DATA;
            end
            ST_DATA: begin
                tx_n = shreg[0];
                if (last && bit_idx == IW'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_n = ST_PARITY;
`else
                    state_n = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_n = par_bit;
                if (last) state_n = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (last) state_n = pop ? ST_START : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Bit timing and shift register; a pop restarts the period for the new start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else if (pop) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_bit <= ^fifo_rdata;
`endif
        end else if (state != ST_IDLE) begin
            if (last) begin
                bit_cnt <= '0;
                if (state == ST_DATA) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 1'b1;
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx   <= 1'b1;
            busy <= 1'b0;
        end else begin
            tx   <= tx_n;
            busy <= (state != ST_IDLE) || !fifo_empty;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-schedule model checked every cycle, plus literal waveform pins.
module tb_uart_tx;

    localparam int DIV   = 10;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;

    uart_tx #(
        .clk_mhz    (50),
        .baud_rate  (5_000_000),
        .fifo_depth (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // One entry per accepted byte: accept edge, edge at which its frame begins, data.
    typedef struct {
        int         a;
        int         start;
        logic [7:0] d;
    } ent_t;

    ent_t q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Line value after edge t: tx lags the frame start edge by one cycle.
    function automatic logic exp_tx(input int t);
        foreach (q[k])
            if (t >= q[k].start + 1 && t < q[k].start + 1 + FRAME)
                return frame_bit(q[k].d, (t - q[k].start - 1) / DIV);
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int t);
        foreach (q[k])
            if (t >= q[k].a + 1 && t < q[k].start + FRAME + 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_ready(input int t);
        int cnt = 0;
        foreach (q[k]) begin
            if (q[k].a <= t)     cnt++;
            if (q[k].start <= t) cnt--;
        end
        return cnt < DEPTH;
    endfunction

    task automatic record(input int a, input logic [7:0] d);
        ent_t e;
        int   pe;
        pe      = (q.size() > 0) ? q[$].start + FRAME : 0;
        e.a     = a;
        e.d     = d;
        e.start = (a + 1 > pe) ? a + 1 : pe;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= 0;
            q.delete();
        end else begin
            if (valid && exp_ready(cyc)) record(cyc + 1, data);
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("tx", {31'd0, tx}, {31'd0, exp_tx(cyc)});
            check("busy", {31'd0, busy}, {31'd0, exp_busy(cyc)});
            check("ready", {31'd0, ready}, {31'd0, exp_ready(cyc)});
        end
    end

    task automatic wait_cyc(input int t);
        int g = 0;
        while (cyc < t && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("wait_cyc", cyc, t);
    endtask

    task automatic send(input logic [7:0] b, output int acc, output int rdy_low);
        int n = q.size();
        int w = 0;
        rdy_low = 0;
        valid   = 1'b1;
        data    = b;
        do begin
            @(negedge clk);
            if (q.size() == n && !ready) rdy_low++;
            w++;
        end while (q.size() == n && w < 2000);
        valid = 1'b0;
        checks++;
        if (q.size() == n) begin
            failures++;
            $display("FAIL send_timeout byte %0h: not accepted after %0d cycles", b, w);
            acc = cyc;
        end else begin
            acc = q[$].a;
        end
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() > 0 && cyc < q[$].start + FRAME + 3 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int a, a1, rl;
        bit [7:0] burst [5];
        burst[0] = 8'hA5; burst[1] = 8'h3C; burst[2] = 8'hFF; burst[3] = 8'h00; burst[4] = 8'h81;

        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ready", {31'd0, ready}, 32'd1);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte 0x55 with literal waveform pins.
        send(8'h55, a, rl);
        wait_cyc(a + 1);         check("single_idle", {31'd0, tx}, 32'd1);
        wait_cyc(a + 2);         check("single_start0", {31'd0, tx}, 32'd0);
        wait_cyc(a + 11);        check("single_start9", {31'd0, tx}, 32'd0);
        wait_cyc(a + 12);        check("single_bit0", {31'd0, tx}, 32'd1);
        wait_cyc(a + 22);        check("single_bit1", {31'd0, tx}, 32'd0);
        wait_cyc(a + 82);        check("single_bit7", {31'd0, tx}, 32'd0);
        wait_cyc(a + FRAME - 8); check("single_stop", {31'd0, tx}, 32'd1);
        wait_cyc(a + FRAME + 1); check("single_busy_hi", {31'd0, busy}, 32'd1);
        wait_cyc(a + FRAME + 2); check("single_busy_lo", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clk);

        // Burst of five, then back-pressure on 0x12.
        send(burst[0], a1, rl);
        for (int i = 1; i < 5; i++) send(burst[i], a, rl);
        check("burst_full", {31'd0, ready}, 32'd0);
        send(8'h12, a, rl);
        checks++;
        if (rl < 40) begin
            failures++;
            $display("FAIL backpressure_wait: ready low %0d cycles, need >= 40", rl);
        end
        wait_cyc(a1 + 2 * FRAME + 1); check("burst_stop2", {31'd0, tx}, 32'd1);
        wait_cyc(a1 + 2 * FRAME + 2); check("burst_start3", {31'd0, tx}, 32'd0);
        drain();

`ifdef UART_TX_PARITY_EN
        send(8'h07, a, rl);
        wait_cyc(a + 91);  check("par07_bit7", {31'd0, tx}, 32'd0);
        wait_cyc(a + 92);  check("par07_parity", {31'd0, tx}, 32'd1);
        wait_cyc(a + 102); check("par07_stop", {31'd0, tx}, 32'd1);
        wait_cyc(a + 111); check("par07_busy_hi", {31'd0, busy}, 32'd1);
        wait_cyc(a + 112); check("par07_busy_lo", {31'd0, busy}, 32'd0);
        send(8'h03, a, rl);
        wait_cyc(a + 92);  check("par03_parity", {31'd0, tx}, 32'd0);
        drain();
`endif

        // Randomized traffic: random gaps (often zero) and random bytes.
        for (int i = 0; i < 25; i++) begin
            int gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 150);
            repeat (gap) @(negedge clk);
            send(8'($urandom), a, rl);
        end
        drain();

        // Reset during data bit 3 of 0xF0 with more bytes queued behind it.
        send(8'hF0, a, rl);
        send(8'h11, a1, rl);
        send(8'h22, a1, rl);
        wait_cyc(a + 45);
        check("rst_pre_tx", {31'd0, tx}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("post_rst_tx", {31'd0, tx}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
